// File: rtl/gf180mcu_nor_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gf180mcu_nor_reduce_pipe
// Description : Parametrised, pipelined wide-NOR (all-zero detector).
//               A GROUP-ary OR tree with one register per level reduces A to
//               a single bit; the last level inverts it to give ZN. A valid bit
//               travels alongside the data. A persistence filter counts
//               consecutive valid ZN=1 results (HITS, saturating at HOLD) and
//               raises STABLE once HOLD of them have been seen.
// Parameters  : WIDTH (2..256), GROUP (2..8), HOLD (1..255).
//               Pipeline latency = ceil(log_GROUP(WIDTH)) cycles, minimum 1.
// Ports       : CLK, RST (async, active-high)
//               A[WIDTH-1:0], IN_VALID            - input sample and qualifier
//               ZN, OUT_VALID                     - registered NOR and qualifier
//               STABLE, HITS[clog2(HOLD+1)-1:0]   - persistence filter state
//               CLR, STICKY                       - only with NOR_REDUCE_STICKY_EN
// Options     : `define NOR_REDUCE_STICKY_EN adds the CLR input and STICKY
//               output (latched record of STABLE rising, cleared by CLR).
// Revision    : 1.0 - initial release
// ============================================================================
module gf180mcu_nor_reduce_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int HOLD  = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             A,
    input  logic                         IN_VALID,
`ifdef NOR_REDUCE_STICKY_EN
    input  logic                         CLR,
    output logic                         STICKY,
`endif
    output logic                         ZN,
    output logic                         OUT_VALID,
    output logic                         STABLE,
    output logic [$clog2(HOLD+1)-1:0]    HITS
);

    // Number of nodes at a given tree level (level 0 is the raw input).
    function automatic int level_width(input int lvl);
        int w;
        w = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            w = (w + GROUP - 1) / GROUP;
        end
        return w;
    endfunction

    // Levels needed to reduce WIDTH bits to one; never fewer than one so the
    // output is always registered.
    function automatic int calc_levels();
        int w;
        int n;
        w = WIDTH;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (w > 1) begin
                w = (w + GROUP - 1) / GROUP;
                n = n + 1;
            end
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

    localparam int c_levels = calc_levels();
    localparam int c_hits_w = $clog2(HOLD + 1);
    localparam logic [c_hits_w-1:0] c_hold = c_hits_w'(HOLD);
    localparam logic [c_hits_w-1:0] c_one  = c_hits_w'(1);

    // ------------------------------------------------------------------
    // Reduction tree: each level ORs GROUP-wide slices of the previous
    // level. The input is zero-extended so a short final node sees zeros
    // on its unused inputs, which cannot disturb an OR.
    // ------------------------------------------------------------------
    for (genvar l = 1; l <= c_levels; l++) begin : g_level
        localparam int c_in_w  = level_width(l - 1);
        localparam int c_out_w = level_width(l);
        localparam int c_pad_w = c_out_w * GROUP;

        logic [c_in_w-1:0]  w_in;
        logic [c_pad_w-1:0] w_pad;
        logic [c_out_w-1:0] w_or;
        logic [c_out_w-1:0] w_d;
        logic [c_out_w-1:0] r_q;

        if (l == 1) begin : g_src_port
            assign w_in = A;
        end else begin : g_src_prev
            assign w_in = g_level[l-1].r_q;
        end

        assign w_pad = c_pad_w'(w_in);

        for (genvar n = 0; n < c_out_w; n++) begin : g_node
            assign w_or[n] = |w_pad[n*GROUP +: GROUP];
        end

        // Only the last level inverts, turning the OR tree into a NOR.
        if (l == c_levels) begin : g_invert
            assign w_d = ~w_or;
        end else begin : g_pass
            assign w_d = w_or;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_q <= '0;
            end else begin
                r_q <= w_d;
            end
        end
    end

    assign ZN = g_level[c_levels].r_q[0];

    // ------------------------------------------------------------------
    // Valid sideband: a shift register matching the tree depth.
    // ------------------------------------------------------------------
    logic [c_levels-1:0] r_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= IN_VALID;
            for (int i = 1; i < c_levels; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign OUT_VALID = r_valid[c_levels-1];

    // ------------------------------------------------------------------
    // Persistence filter. It acts on the registered ZN/OUT_VALID, so HITS
    // trails the result it counts by one cycle. Invalid slots hold state.
    // ------------------------------------------------------------------
    logic [c_hits_w-1:0] r_hits;
    logic [c_hits_w-1:0] w_hits_next;
    logic                r_stable;
    logic                w_stable_next;

    always_comb begin
        w_hits_next = r_hits;
        if (OUT_VALID) begin
            if (ZN) begin
                if (r_hits != c_hold) begin
                    w_hits_next = r_hits + c_one;
                end
            end else begin
                w_hits_next = '0;
            end
        end
    end

    assign w_stable_next = (w_hits_next == c_hold);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hits   <= '0;
            r_stable <= 1'b0;
        end else begin
            r_hits   <= w_hits_next;
            r_stable <= w_stable_next;
        end
    end

    assign HITS   = r_hits;
    assign STABLE = r_stable;

`ifdef NOR_REDUCE_STICKY_EN
    // Sets on the edge STABLE rises; a simultaneous CLR loses to the set.
    logic r_sticky;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sticky <= 1'b0;
        end else if (w_stable_next && !r_stable) begin
            r_sticky <= 1'b1;
        end else if (CLR) begin
            r_sticky <= 1'b0;
        end
    end

    assign STICKY = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_nor_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf180mcu_nor_reduce_pipe
// Description : Scoreboard bench for gf180mcu_nor_reduce_pipe. Directed vectors
//               push hand-computed expectations (ZN plus the HITS/STABLE
//               values once that result has been absorbed by the filter); a
//               monitor pops one entry per OUT_VALID and compares. A second
//               instance (WIDTH=10) covers the short-final-node case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_nor_reduce_pipe;

    typedef struct {
        logic       zn;
        logic [1:0] hits;
        logic       stable;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic [15:0] A;
    logic        IN_VALID;
    logic        ZN;
    logic        OUT_VALID;
    logic        STABLE;
    logic [1:0]  HITS;

    logic [9:0]  a_r;
    logic        v_r;
    logic        zn_r;
    logic        ov_r;
    logic        stable_r;
    logic [1:0]  hits_r;

`ifdef NOR_REDUCE_STICKY_EN
    logic        CLR;
    logic        STICKY;
    logic        sticky_r;
`endif

    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];
    exp_t pend_e;
    logic pend;

    gf180mcu_nor_reduce_pipe #(.WIDTH(16), .GROUP(4), .HOLD(3)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .IN_VALID  (IN_VALID),
`ifdef NOR_REDUCE_STICKY_EN
        .CLR       (CLR),
        .STICKY    (STICKY),
`endif
        .ZN        (ZN),
        .OUT_VALID (OUT_VALID),
        .STABLE    (STABLE),
        .HITS      (HITS)
    );

    gf180mcu_nor_reduce_pipe #(.WIDTH(10), .GROUP(4), .HOLD(3)) u_dut_r (
        .CLK       (CLK),
        .RST       (RST),
        .A         (a_r),
        .IN_VALID  (v_r),
`ifdef NOR_REDUCE_STICKY_EN
        .CLR       (1'b0),
        .STICKY    (sticky_r),
`endif
        .ZN        (zn_r),
        .OUT_VALID (ov_r),
        .STABLE    (stable_r),
        .HITS      (hits_r)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one sample for one clock; valid samples carry their expectation.
    task automatic drive(input logic [15:0] a, input logic v,
                         input logic ezn, input logic [1:0] ehits, input logic est);
        exp_t e;
        A        = a;
        IN_VALID = v;
        if (v) begin
            e.zn     = ezn;
            e.hits   = ehits;
            e.stable = est;
            sb_q.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        A        = 16'hFFFF;
        IN_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: ZN is checked when presented; HITS/STABLE are checked one
    // cycle later, after the filter has absorbed that result.
    always @(negedge CLK) begin
        if (!RST) begin
            if (pend) begin
                chk("hits", 32'(HITS), 32'(pend_e.hits));
                chk("stable", 32'(STABLE), 32'(pend_e.stable));
                pend = 1'b0;
            end
            if (OUT_VALID) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(OUT_VALID), 32'd0);
                end else begin
                    pend_e = sb_q.pop_front();
                    chk("zn", 32'(ZN), 32'(pend_e.zn));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        pend     = 1'b0;
        RST      = 1'b1;
        A        = 16'h0000;
        IN_VALID = 1'b0;
        a_r      = 10'h000;
        v_r      = 1'b0;
`ifdef NOR_REDUCE_STICKY_EN
        CLR      = 1'b0;
`endif
        #1;
        chk("reset_zn", 32'(ZN), 32'd0);
        chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
        chk("reset_hits", 32'(HITS), 32'd0);
        chk("reset_stable", 32'(STABLE), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Short final node on the WIDTH=10 instance (10 -> 3 -> 1).
        a_r = 10'h200; v_r = 1'b1; @(negedge CLK);
        a_r = 10'h000;             @(negedge CLK);
        chk("rem_ov", 32'(ov_r), 32'd1);
        chk("rem_zn_200", 32'(zn_r), 32'd0);
        a_r = 10'h100;             @(negedge CLK);
        chk("rem_zn_000", 32'(zn_r), 32'd1);
        v_r = 1'b0; a_r = 10'h000; @(negedge CLK);
        chk("rem_zn_100", 32'(zn_r), 32'd0);
        idle(2);

        // Latency and basic NOR.
        drive(16'h0000, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(16'h0100, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("latency_ov", 32'(OUT_VALID), 32'd1);
        chk("latency_zn", 32'(ZN), 32'd1);
        idle(3);

        // Filter build-up, saturation, and drop on a non-zero.
        drive(16'h0000, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd3, 1'b1);
        drive(16'h0000, 1'b1, 1'b1, 2'd3, 1'b1);
        drive(16'h0001, 1'b1, 1'b0, 2'd0, 1'b0);
        drive(16'h8000, 1'b1, 1'b0, 2'd0, 1'b0);
        drive(16'h0010, 1'b1, 1'b0, 2'd0, 1'b0);

        // Bubbles do not break the streak; invalid data is ignored.
        drive(16'h0000, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(16'hFFFF, 1'b0, 1'b0, 2'd0, 1'b0);
        drive(16'h0400, 1'b0, 1'b0, 2'd0, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd3, 1'b1);
        idle(4);

        // Mid-stream reset discards everything in flight.
        drive(16'h0000, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd2, 1'b0);
        #1 RST = 1'b1;
        #1;
        chk("midrst_hits", 32'(HITS), 32'd0);
        chk("midrst_stable", 32'(STABLE), 32'd0);
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        sb_q.delete();
        pend = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        drive(16'h0000, 1'b1, 1'b1, 2'd1, 1'b0);
        chk("postrst_ov_0", 32'(OUT_VALID), 32'd0);
        drive(16'h0000, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd3, 1'b1);
        idle(4);

`ifdef NOR_REDUCE_STICKY_EN
        chk("sticky_set", 32'(STICKY), 32'd1);
        drive(16'h0001, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(3);
        chk("sticky_hold_after_nonzero", 32'(STICKY), 32'd1);
        CLR = 1'b1; @(negedge CLK); CLR = 1'b0;
        chk("sticky_clr", 32'(STICKY), 32'd0);
        drive(16'h0000, 1'b1, 1'b1, 2'd1, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd2, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 2'd3, 1'b1);
        idle(1);
        CLR = 1'b1;
        idle(1);
        CLR = 1'b0;
        chk("sticky_set_wins_stable", 32'(STABLE), 32'd1);
        chk("sticky_set_wins", 32'(STICKY), 32'd1);
        idle(3);
`endif

        idle(4);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf180mcu_nor_reduce_pipe.md
Name: gf180mcu_nor_reduce_pipe

Overview:
- Parametrised, pipelined wide-NOR (all-zero detector): ZN=1 when every bit of A is 0.
- Successor to the fixed 4-input NOR cell. Generalised width, with a GROUP-ary registered reduction tree and a valid sideband.
- Adds a persistence filter: STABLE asserts after HOLD consecutive valid all-zero results.
- Sits in MCU datapaths as a zero/idle detector, e.g. bus-idle or counter-expired qualification.

Parameters:
- WIDTH, 16, number of input bits; legal range 2..256.
- GROUP, 4, fan-in per reduction node; legal range 2..8.
- HOLD, 3, consecutive valid ZN=1 results required to assert STABLE; legal range 1..255.
- LEVELS, derived (not overridable): ceil(log_GROUP(WIDTH)), minimum 1; equals pipeline latency in cycles.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- A  input  WIDTH  data sampled on each CLK rising edge.
- IN_VALID  input  1  A is meaningful this cycle.
- ZN  output  1  registered NOR of A, valid when OUT_VALID=1.
- OUT_VALID  output  1  IN_VALID delayed by LEVELS cycles.
- STABLE  output  1  filtered all-zero indication.
- HITS  output  clog2(HOLD+1)  consecutive-zero count, saturating at HOLD.

Behaviour:
- Reset: RST=1 asynchronously clears all pipeline registers, OUT_VALID, HITS and STABLE to 0. ZN resets to 0, not 1.
- Clock 0 (reset edge): one reset edge is enough; the block operates normally from the first CLK edge after RST deasserts.
- Tree levels 1..LEVELS-1: each node ORs up to GROUP bits of the previous level. If the level width is not a multiple of GROUP, the last node takes the remainder and unused inputs are tied to 0.
- Final level: inverts its OR result, producing NOR.
- Pipelining: every level is registered. A sampled at edge k appears on ZN at edge k+LEVELS-1, i.e. LEVELS cycles of latency with full throughput.
- No backpressure: the pipeline advances every cycle regardless of IN_VALID.
- Valid sideband: a valid bit shifts alongside the data; OUT_VALID=1 marks a ZN that reflects a valid sample.
- Invalid data: tree registers load whatever A holds. Only OUT_VALID qualifies ZN; the filter ignores invalid slots.
- Filter, on each edge:
  - OUT_VALID=1 and ZN=1: HITS <= min(HITS+1, HOLD).
  - OUT_VALID=1 and ZN=0: HITS <= 0.
  - OUT_VALID=0: HITS holds.
- STABLE is registered and equals (HITS==HOLD) after the same edge's update, i.e. STABLE is a combinational compare of the updated HITS, registered.
- Saturation: HITS never wraps. STABLE stays 1 while valid zeros continue and drops on the edge a valid ZN=0 arrives.
- Bubbles: invalid slots between valid zeros do not break the streak.
- RST asserted mid-stream discards all in-flight samples. OUT_VALID stays 0 for LEVELS cycles after release.

Optional Feature:
- Macro NOR_REDUCE_STICKY_EN.
- When defined, adds input CLR (1 bit) and output STICKY (1 bit).
  - STICKY sets on any edge where STABLE becomes 1.
  - STICKY clears on an edge with CLR=1.
  - If set and clear occur on the same edge, set wins.
  - STICKY resets to 0 on RST.
- When undefined, the CLR and STICKY ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Latency, WIDTH=16, GROUP=4 (LEVELS=2): A=0x0000 with IN_VALID=1 at edge 0 -> OUT_VALID=1, ZN=1 after edge 1. A=0x0100 at edge 1 -> ZN=0 after edge 2.
- Remainder tie-off, WIDTH=10, GROUP=4: A=0x200 -> ZN=0. A=0x000 -> ZN=1.
- Filter, HOLD=3: three consecutive valid zeros -> HITS 1,2,3 and STABLE=1 after the third. A fourth valid zero -> HITS stays 3.
  - A valid 0x0001 -> HITS=0 and STABLE=0 on that result's edge.
- Bubbles: valid zero, IN_VALID=0 for 2 cycles, then two valid zeros -> STABLE=1 after the 3rd valid zero. Pulsing RST mid-sequence -> HITS=0, STABLE=0 immediately, OUT_VALID=0 for 2 cycles after release.
- NOR_REDUCE_STICKY_EN: reach STABLE=1 -> STICKY=1. Then a valid non-zero -> STICKY still 1. Then CLR=1 -> STICKY=0. CLR=1 on the same edge as STABLE rises -> STICKY=1.
